avalon_st_reg_slice: RTL and testbench
======================================

Name: avalon_st_reg_slice

Overview:
- Full-throughput registered pipeline stage (skid buffer) for the Avalon-ST stream.
- Accepts beats on an avalon_st_if slave modport and re-drives them on an avalon_st_if master modport.
- Breaks the combinational paths on both the forward (data/valid) and backward (rdy) directions.
- Also checks packet framing and flags violations without altering the stream.
- Used between blocks wherever timing closure needs a register on all stream signals.

Parameters:
- DATA_WIDTH_IN_BYTES, 16, bytes per beat. Must match both connected interfaces. Empty width is log2up(DATA_WIDTH_IN_BYTES) via generic_func_pack::log2up_func.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_stream  avalon_st_if.slave  bundle  upstream stream. Inputs: data, empty, valid, sop, eop. Output: rdy.
- out_stream  avalon_st_if.master  bundle  downstream stream. Outputs: data, empty, valid, sop, eop. Input: rdy.
- framing_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Transfer rule: a beat transfers on a rising clk edge when valid=1 and rdy=1 on that interface.
- Holding rule: while out_stream.valid=1 and out_stream.rdy=0, all out_stream signals are held stable.
- Storage: two entries.
  - Output register drives out_stream directly.
  - Skid register holds one additional beat.
- in_stream.rdy is a register output, equal to "skid register empty". It is never combinationally derived from out_stream.rdy.
- Reset (async, while rst=1):
  - out_stream valid, sop, eop, data, empty = 0 (CLEAR_MASTER values).
  - in_stream.rdy = 1 (CLEAR_SLAVE value).
  - Skid register empty; framing_err = 0; in-packet state = idle.
  - No beat is captured while rst=1.
  - Reset mid-packet discards all buffered beats. After reset the first accepted beat must carry sop to avoid a framing error.
- Latency: an accepted beat appears on out_stream on the next cycle if the output register is empty or draining that cycle.
- Throughput: 1 beat/cycle sustained while out_stream.rdy=1.
- Per-edge update:
  - Output register empty or draining (out.valid=0, or out.rdy=1), skid register full → move skid to output; skid becomes empty.
  - Output register empty or draining, skid empty, input transfer occurs → load the input beat into output.
  - Output register stalled (out.valid=1, out.rdy=0), input transfer occurs → load the input beat into skid; rdy drops to 0 next cycle.
  - Output register draining, skid full, in_stream.rdy=0 → no input accepted this edge. Skid moves to output; rdy returns to 1 next cycle.
- Ordering: beats are never reordered, duplicated or dropped.
- Field handling: data, empty, sop and eop travel with their beat unchanged.
- Framing checker (evaluated on in_stream transfers only):
  - Tracks an in-packet flag. sop sets it, eop clears it; a beat with sop and eop both set is a one-beat packet and leaves the flag clear.
  - framing_err pulses for one cycle (registered, asserted the cycle after the offending transfer) when any of:
    - sop=1 while in-packet;
    - sop=0 while idle;
    - empty≠0 on a beat with eop=0.
  - Offending beats are still forwarded. The flag update uses the beat's sop/eop regardless of the error.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → out valid/sop/eop/data/empty read 0 immediately, in rdy=1, framing_err=0. Release rst → first transfer of {sop=1, data=0x0F..00} appears on out one cycle later.
- Streaming: 8-beat packet (data = beat index 0..7; sop on beat 0; eop and empty=3 on beat 7), out rdy held 1 → 8 consecutive output cycles, identical fields, in rdy stays 1, framing_err never pulses.
- Backpressure: out rdy=0 for 3 cycles during a 4-beat packet → output register + skid fill, in rdy=0 from the cycle after the 2nd buffered beat. Out fields stay stable while stalled. Release rdy → all 4 beats delivered in order, none lost.
- Random valid/rdy: 1000 beats, random 50% valid and rdy, scoreboard compare → exact in-order match. in rdy is never low while the skid register is empty.
- Framing errors:
  - sop beat, then another sop before eop → framing_err=1 for exactly one cycle.
  - Non-sop beat while idle → framing_err=1.
  - empty=5 on a mid-packet beat → framing_err=1.
  - All three offending beats are still forwarded unchanged.
- Single-beat packet: sop=1, eop=1, empty=15 → forwarded unchanged, framing_err=0; checker returns to idle and the next sop beat raises no error.

Source files
------------

// File: rtl/generic_func_pack.sv
// Small elaboration-time helper functions shared by stream blocks.
package generic_func_pack;

  // Bits needed to index 'value' items; never less than 1 so a 1-byte bus still has a field.
  function automatic int unsigned log2up_func(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: byte-wide data, empty count, valid/sop/eop forward, rdy backward.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
  localparam int unsigned EMPTY_WIDTH = generic_func_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic [EMPTY_WIDTH-1:0]           empty;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic                             rdy;

  modport master (output data, empty, valid, sop, eop, input rdy);
  modport slave  (input data, empty, valid, sop, eop, output rdy);
endinterface

// File: rtl/avalon_st_reg_slice.sv
// Two-entry skid buffer registering every Avalon-ST signal in both directions,
// with a passive packet-framing checker on the input side.
module avalon_st_reg_slice #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  in_stream,
  avalon_st_if.master out_stream,
  output logic        framing_err
);
  localparam int unsigned DataW  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned EmptyW = generic_func_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  typedef struct packed {
    logic [DataW-1:0]  data;
    logic [EmptyW-1:0] empty;
    logic              sop;
    logic              eop;
  } beat_t;

  beat_t w_in_beat;
  beat_t r_out_beat;
  beat_t r_skid_beat;
  logic  r_out_valid;
  logic  r_skid_valid;
  logic  r_in_rdy;
  logic  r_in_pkt;
  logic  r_framing_err;
  logic  w_in_xfer;
  logic  w_out_free;
  logic  w_frame_bad;

  assign w_in_beat.data  = in_stream.data;
  assign w_in_beat.empty = in_stream.empty;
  assign w_in_beat.sop   = in_stream.sop;
  assign w_in_beat.eop   = in_stream.eop;

  assign w_in_xfer  = in_stream.valid & r_in_rdy;
  assign w_out_free = ~r_out_valid | out_stream.rdy;

  // Datapath: output register first, skid only when the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_beat   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_beat  <= '0;
      r_skid_valid <= 1'b0;
      r_in_rdy     <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // in_rdy is low here, so nothing new can arrive this edge.
        r_out_beat   <= r_skid_beat;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_rdy     <= 1'b1;
      end else begin
        r_out_valid <= w_in_xfer;
        if (w_in_xfer) r_out_beat <= w_in_beat;
      end
    end else if (w_in_xfer) begin
      r_skid_beat  <= w_in_beat;
      r_skid_valid <= 1'b1;
      r_in_rdy     <= 1'b0;
    end
  end

  assign w_frame_bad = (in_stream.sop & r_in_pkt)
                     | (~in_stream.sop & ~r_in_pkt)
                     | (~in_stream.eop & (in_stream.empty != '0));

  // Checker only observes; eop wins so a sop+eop beat leaves the flag clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_pkt      <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_framing_err <= w_in_xfer & w_frame_bad;
      if (w_in_xfer) begin
        if (in_stream.eop)      r_in_pkt <= 1'b0;
        else if (in_stream.sop) r_in_pkt <= 1'b1;
      end
    end
  end

  assign in_stream.rdy    = r_in_rdy;
  assign out_stream.valid = r_out_valid;
  assign out_stream.data  = r_out_beat.data;
  assign out_stream.empty = r_out_beat.empty;
  assign out_stream.sop   = r_out_beat.sop;
  assign out_stream.eop   = r_out_beat.eop;
  assign framing_err      = r_framing_err;

endmodule

// File: tb/tb_avalon_st_reg_slice.sv
// Directed and randomized checks of the Avalon-ST register slice against a
// FIFO scoreboard plus hand-computed framing and backpressure expectations.
module tb_avalon_st_reg_slice;
  localparam int unsigned NB = 16;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   empty;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic framing_err;

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) out_if ();

  avalon_st_reg_slice #(.DATA_WIDTH_IN_BYTES(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_stream   (in_if),
    .out_stream  (out_if),
    .framing_err (framing_err)
  );

  int    n_vec   = 0;
  int    n_miss  = 0;
  int    n_out   = 0;
  int    n_err   = 0;
  int    run     = 0;
  int    max_run = 0;
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [127:0] d, input logic [3:0] e,
                               input logic s, input logic o);
    beat_t b;
    b.data  = d;
    b.empty = e;
    b.sop   = s;
    b.eop   = o;
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic v);
    in_if.data  = b.data;
    in_if.empty = b.empty;
    in_if.sop   = b.sop;
    in_if.eop   = b.eop;
    in_if.valid = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the beat valid until it transfers; returns #1 after the transfer edge.
  task automatic send(input beat_t b);
    bit done;
    done = 1'b0;
    drive(b, 1'b1);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_if.rdy;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_if.valid = 1'b0;
  endtask

  // Scoreboard: occupancy of the slice equals beats accepted but not yet delivered.
  initial begin
    beat_t ob;
    beat_t eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        run = 0;
      end else begin
        check("in_rdy_vs_occupancy", in_if.rdy, exp_q.size() < 2);
        if (out_if.valid && out_if.rdy) begin
          ob.data  = out_if.data;
          ob.empty = out_if.empty;
          ob.sop   = out_if.sop;
          ob.eop   = out_if.eop;
          if (exp_q.size() == 0) begin
            check("out_spurious", 1, 0);
          end else begin
            eb = exp_q.pop_front();
            check("out_beat", ob, eb);
          end
          n_out++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (in_if.valid && in_if.rdy) begin
          exp_q.push_back(mk(in_if.data, in_if.empty, in_if.sop, in_if.eop));
        end
        if (framing_err) n_err++;
      end
    end
  end

  initial begin
    beat_t b;
    int    o0;
    int    e0;
    int    idx;
    int    pos;
    int    len;
    int    guard;
    bit    acc;

    rst = 1'b1;
    drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
    out_if.rdy = 1'b0;
    #12;
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_sop", out_if.sop, 0);
    check("rst_out_eop", out_if.eop, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_out_empty", out_if.empty, 0);
    check("rst_in_rdy", in_if.rdy, 1);
    check("rst_ferr", framing_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(mk(128'h0F0E0D0C0B0A09080706050403020100, 4'd0, 1'b1, 1'b0));
    idle();
    check("first_valid", out_if.valid, 1);
    check("first_data", out_if.data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("first_sop", out_if.sop, 1);
    check("first_ferr", framing_err, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", out_if.valid, 0);
    check("arst_data", out_if.data, 0);
    check("arst_sop", out_if.sop, 0);
    check("arst_in_rdy", in_if.rdy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming: 8 beats back to back with the sink always ready.
    out_if.rdy = 1'b1;
    o0 = n_out;
    e0 = n_err;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      send(mk(128'(i), (i == 7) ? 4'd3 : 4'd0, i == 0, i == 7));
    end
    idle();
    cycles(3);
    check("stream_count", n_out - o0, 8);
    check("stream_run", max_run, 8);
    check("stream_ferr", n_err - e0, 0);

    // Backpressure: fill output and skid, hold, then drain.
    out_if.rdy = 1'b0;
    o0 = n_out;
    e0 = n_err;
    send(mk(128'hA0, 4'd0, 1'b1, 1'b0));
    check("bp_rdy_after_1", in_if.rdy, 1);
    send(mk(128'hA1, 4'd0, 1'b0, 1'b0));
    check("bp_rdy_after_2", in_if.rdy, 0);
    drive(mk(128'hA2, 4'd0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      check("bp_hold_data", out_if.data, 128'hA0);
      check("bp_hold_valid", out_if.valid, 1);
      check("bp_hold_sop", out_if.sop, 1);
      check("bp_hold_in_rdy", in_if.rdy, 0);
    end
    check("bp_no_out", n_out - o0, 0);
    out_if.rdy = 1'b1;
    send(mk(128'hA2, 4'd0, 1'b0, 1'b0));
    send(mk(128'hA3, 4'd0, 1'b0, 1'b1));
    idle();
    cycles(4);
    check("bp_count", n_out - o0, 4);
    check("bp_ferr", n_err - e0, 0);

    // Random valid/rdy with legal packets of 1..4 beats.
    o0 = n_out;
    e0 = n_err;
    idx = 0;
    pos = 0;
    guard = 0;
    len = $urandom_range(1, 4);
    b.data  = {$urandom, $urandom, $urandom, $urandom};
    b.sop   = (pos == 0);
    b.eop   = (pos == len - 1);
    b.empty = b.eop ? 4'($urandom_range(0, 15)) : 4'd0;
    drive(b, 1'($urandom_range(0, 1)));
    out_if.rdy = 1'($urandom_range(0, 1));
    while (idx < 1000 && guard < 20000) begin
      @(negedge clk);
      acc = in_if.valid && in_if.rdy;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (b.eop) begin
          pos = 0;
          len = $urandom_range(1, 4);
        end else begin
          pos++;
        end
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.sop   = (pos == 0);
        b.eop   = (pos == len - 1);
        b.empty = b.eop ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      drive(b, (idx < 1000) ? 1'($urandom_range(0, 1)) : 1'b0);
      out_if.rdy = 1'($urandom_range(0, 1));
    end
    idle();
    out_if.rdy = 1'b1;
    cycles(4);
    check("rand_guard", guard < 20000, 1);
    check("rand_count", n_out - o0, 1000);
    check("rand_ferr", n_err - e0, 0);
    check("rand_q_empty", exp_q.size(), 0);

    // Framing violations, starting from a clean idle state.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    o0 = n_out;
    e0 = n_err;
    send(mk(128'hB0, 4'd0, 1'b1, 1'b0));
    check("fe_legal_sop", framing_err, 0);
    send(mk(128'hB1, 4'd0, 1'b1, 1'b0));
    check("fe_double_sop", framing_err, 1);
    send(mk(128'hB2, 4'd0, 1'b0, 1'b1));
    check("fe_clear_1", framing_err, 0);
    send(mk(128'hB3, 4'd0, 1'b0, 1'b1));
    check("fe_no_sop", framing_err, 1);
    send(mk(128'hB4, 4'd0, 1'b1, 1'b0));
    check("fe_clear_2", framing_err, 0);
    send(mk(128'hB5, 4'd5, 1'b0, 1'b0));
    check("fe_bad_empty", framing_err, 1);
    send(mk(128'hB6, 4'd0, 1'b0, 1'b1));
    check("fe_clear_3", framing_err, 0);
    idle();
    cycles(3);
    check("fe_pulses", n_err - e0, 3);
    check("fe_forwarded", n_out - o0, 7);

    // Single-beat packet, then a normal packet must raise nothing.
    e0 = n_err;
    send(mk(128'hC0, 4'd15, 1'b1, 1'b1));
    check("sb_ferr", framing_err, 0);
    check("sb_out_empty", out_if.empty, 15);
    check("sb_out_sop_eop", {out_if.sop, out_if.eop}, 2'b11);
    send(mk(128'hC1, 4'd0, 1'b1, 1'b0));
    check("sb_next_sop", framing_err, 0);
    send(mk(128'hC2, 4'd0, 1'b0, 1'b1));
    check("sb_next_eop", framing_err, 0);
    idle();
    cycles(3);
    check("sb_pulses", n_err - e0, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
